// File: rtl/fp_intcast_i2f_fp32.sv
// Signed INT32 to FP32 converter, round-to-nearest-even, three-stage valid/ready pipeline with a global stall.
// Optional build macro FP_I2F_UNSIGNED_EN adds the in_unsigned port for unsigned operands.
module fp_intcast_i2f_fp32 #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
`ifdef FP_I2F_UNSIGNED_EN
    input  logic             in_unsigned,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_inexact,
    output logic [TAG_W-1:0] out_tag
);

    // Leading-zero count; an all-zero word wraps to 0 and is flagged separately.
    function automatic logic [4:0] lzc32(input logic [31:0] v);
        logic [4:0] n;
        logic       hit;
        n   = 5'd0;
        hit = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (hit || v[i]) begin
                hit = 1'b1;
            end else begin
                n = n + 5'd1;
            end
        end
        return n;
    endfunction

    logic             adv_s;

    logic             v1_r;
    logic             sign1_r;
    logic [31:0]      mag1_r;
    logic [TAG_W-1:0] tag1_r;

    logic             v2_r;
    logic             sign2_r;
    logic             zero2_r;
    logic [30:0]      norm2_r;
    logic [7:0]       exp2_r;
    logic [TAG_W-1:0] tag2_r;

    logic             v3_r;
    logic [31:0]      data3_r;
    logic             nx3_r;
    logic [TAG_W-1:0] tag3_r;

    logic             uns_s;
    logic             sign1_s;
    logic [31:0]      mag1_s;
    logic [4:0]       lz2_s;
    logic [30:0]      norm2_s;
    logic [7:0]       exp2_s;
    logic             zero2_s;
    logic [22:0]      man3_s;
    logic             g3_s;
    logic             st3_s;
    logic             rnd3_s;
    logic [23:0]      man_inc3_s;
    logic [7:0]       exp3_s;
    logic [31:0]      data3_s;
    logic             nx3_s;

    // The whole pipe advances together; empty stages are not compressed.
    assign adv_s    = !v3_r || out_ready;
    assign in_ready = adv_s;

    // S1: sign and magnitude; -2^31 negates to 0x80000000, which is exactly its magnitude.
    always_comb begin
`ifdef FP_I2F_UNSIGNED_EN
        uns_s = in_unsigned;
`else
        uns_s = 1'b0;
`endif
        sign1_s = in_data[31] & ~uns_s;
        if (sign1_s) begin
            mag1_s = 32'd0 - in_data;
        end else begin
            mag1_s = in_data;
        end
    end

    // S2: normalize so the leading one sits at bit 31 (dropped as the hidden bit).
    always_comb begin
        lz2_s   = lzc32(mag1_r);
        norm2_s = 31'(mag1_r << lz2_s);
        exp2_s  = 8'd158 - {3'd0, lz2_s};
        zero2_s = (mag1_r == 32'd0);
    end

    // S3: RNE rounding; a mantissa carry leaves the fraction zero and bumps the exponent.
    always_comb begin
        man3_s     = norm2_r[30:8];
        g3_s       = norm2_r[7];
        st3_s      = |norm2_r[6:0];
        rnd3_s     = g3_s & (st3_s | man3_s[0]);
        man_inc3_s = {1'b0, man3_s} + {23'd0, rnd3_s};
        if (man_inc3_s[23]) begin
            exp3_s = exp2_r + 8'd1;
        end else begin
            exp3_s = exp2_r;
        end
        if (zero2_r) begin
            data3_s = 32'd0;
            nx3_s   = 1'b0;
        end else begin
            data3_s = {sign2_r, exp3_s, man_inc3_s[22:0]};
            nx3_s   = g3_s | st3_s;
        end
    end

    // Pipeline registers: cleared by reset, shifted together on advance, frozen otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r    <= 1'b0;
            sign1_r <= 1'b0;
            mag1_r  <= 32'd0;
            tag1_r  <= '0;
            v2_r    <= 1'b0;
            sign2_r <= 1'b0;
            zero2_r <= 1'b0;
            norm2_r <= 31'd0;
            exp2_r  <= 8'd0;
            tag2_r  <= '0;
            v3_r    <= 1'b0;
            data3_r <= 32'd0;
            nx3_r   <= 1'b0;
            tag3_r  <= '0;
        end else if (adv_s) begin
            v1_r    <= in_valid;
            sign1_r <= sign1_s;
            mag1_r  <= mag1_s;
            tag1_r  <= in_tag;
            v2_r    <= v1_r;
            sign2_r <= sign1_r;
            zero2_r <= zero2_s;
            norm2_r <= norm2_s;
            exp2_r  <= exp2_s;
            tag2_r  <= tag1_r;
            v3_r    <= v2_r;
            data3_r <= data3_s;
            nx3_r   <= nx3_s;
            tag3_r  <= tag2_r;
        end
    end

    assign out_valid   = v3_r;
    assign out_data    = data3_r;
    assign out_inexact = nx3_r;
    assign out_tag     = tag3_r;

endmodule
